vec_len_sq: RTL and testbench
=============================

VEC_LEN_SQ -- requirements
Module: vec_len_sq

Interface
REQ-001 The block SHALL have parameter W, default 12, setting the width of input components and output value.
REQ-002 The block SHALL have parameter FRAC, default 4, setting the fixed-point fraction bits of the inputs and the output.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_, input, 1 bit: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1 bit: a vector is offered on x, y and z.
REQ-007 Port in_ready, output, 1 bit: the block can accept a vector.
REQ-008 Port x, input, W bits: signed two's-complement component with FRAC fraction bits.
REQ-009 Port y, input, W bits: signed component, same format as x.
REQ-010 Port z, input, W bits: signed component, same format as x.
REQ-011 Port ds_busy, input, 1 bit: the downstream square-root stage is not ready for a new start.
REQ-012 Port sq_out, output, W bits: unsigned x²+y²+z² with FRAC fraction bits; this is the downstream square-root input.
REQ-013 Port sq_start, output, 1 bit: single-cycle start pulse to the downstream stage.
REQ-014 Port sq_sat, output, 1 bit: the current sq_out value was saturated.

Function
REQ-015 The FSM SHALL have the states IDLE, MUL_X, MUL_Y, MUL_Z, SUM and ISSUE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1.
REQ-018 On a transfer, x, y and z SHALL be registered, the accumulator SHALL be cleared, and the state SHALL move to MUL_X.
REQ-019 Inputs SHALL be ignored outside the transfer edge.
REQ-020 The block SHALL use a single W×W signed multiplier, time-shared over three cycles.
REQ-021 In the MUL_X, MUL_Y and MUL_Z states, the block SHALL add (component², shifted right by FRAC, truncated) to an unsigned accumulator of at least 2W+2 bits.
REQ-022 The states SHALL advance MUL_X→MUL_Y→MUL_Z→SUM unconditionally.
REQ-023 In SUM, the next sq_out SHALL be the accumulator clamped to 2^W−1, and the next sq_sat SHALL be 1 iff the clamp applied; the state SHALL then move to ISSUE.
REQ-024 sq_out and sq_sat SHALL update only at the SUM→ISSUE edge.
REQ-025 sq_out and sq_sat SHALL hold until the next SUM→ISSUE edge, because the downstream stage samples sq_out over several cycles after the start pulse.
REQ-026 In ISSUE with ds_busy=0, sq_start SHALL be 1 for that cycle and the state SHALL return to IDLE.
REQ-027 In ISSUE with ds_busy=1, sq_start SHALL be 0 and the state SHALL remain ISSUE.
REQ-028 sq_start SHALL never be high for two consecutive cycles.
REQ-029 Latency SHALL be as follows: with the transfer at edge T and ds_busy=0, sq_start SHALL be high in the cycle after edge T+4, with sq_out valid in that same cycle.
REQ-030 Throughput SHALL be one vector per 6 cycles at most.
REQ-031 in_ready SHALL be high in the cycle after the sq_start cycle.
REQ-032 A negative component SHALL give the same square as its magnitude.
REQ-033 The most negative value (−2^(W−1)) SHALL square correctly, with no overflow inside the product.
REQ-034 Squares smaller than 2^−FRAC SHALL truncate to 0.
REQ-035 A ds_busy change during MUL_X through SUM SHALL have no effect; ds_busy SHALL be sampled only in ISSUE.

Reset
REQ-036 While rst_=0, the block SHALL asynchronously set the state to IDLE, in_ready=1, sq_out=0, sq_sat=0, sq_start=0, and clear the accumulator and component registers.
REQ-037 A reset during any state SHALL abort the computation with no sq_start pulse.
REQ-038 The first transfer after reset deassertion SHALL be possible on the first rising edge with rst_=1.

Verification
REQ-039 Scenario 1: x=0x010 (1.0), y=0, z=0, ds_busy=0 -> sq_out=0x010 and sq_sat=0; sq_start pulses exactly once, in the cycle after edge T+4.
REQ-040 Scenario 2: x=y=z=0x020 (2.0) -> sq_out=0x0C0 (12.0); then x=0xFD0 (−3.0), y=z=0 -> sq_out=0x090 (9.0).
REQ-041 Scenario 3: x=0x7FF and x=0x800 (y=z=0) -> sq_out=0xFFF and sq_sat=1; a following vector x=0x001 (0.0625) -> sq_out=0x000 and sq_sat=0.
REQ-042 Scenario 4: ds_busy=1 for 3 cycles of ISSUE, then 0 -> sq_start=0 during those 3 cycles, then a single 1-cycle pulse; sq_out is stable throughout; in_ready stays 0 until after the pulse.
REQ-043 Scenario 5: rst_=0 asserted asynchronously mid-MUL_Y -> all outputs reach their reset values without a clock edge; after release, a new vector x=0x010, y=0, z=0 gives sq_out=0x010 with normal latency.
REQ-044 Scenario 6: in_valid held high continuously over 4 vectors -> each is accepted only when in_ready=1, with exactly one sq_start per vector, at least 6 cycles apart.

Source files
------------

// File: rtl/vec_len_sq.sv
// Squared length of a signed fixed-point 3-vector. One shared multiplier squares
// x, y and z in turn; the saturated sum is handed to a downstream square-root stage.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for a vector
// MUL_X | accumulate x^2 >> FRAC
// MUL_Y | accumulate y^2 >> FRAC
// MUL_Z | accumulate z^2 >> FRAC
// SUM   | clamp accumulator into sq_out / sq_sat
// ISSUE | pulse sq_start once the downstream stage is not busy
module vec_len_sq #(
    parameter int W    = 12,
    parameter int FRAC = 4
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] z,
    input  logic                ds_busy,
    output logic [W-1:0]        sq_out,
    output logic                sq_start,
    output logic                sq_sat
);

    localparam int ACC_W = 2*W + 2;
    localparam logic [ACC_W-1:0] SAT_LIMIT = {{(ACC_W-W){1'b0}}, {W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_X = 3'd1,
        MUL_Y = 3'd2,
        MUL_Z = 3'd3,
        SUM   = 3'd4,
        ISSUE = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0]   x_q, y_q, z_q;
    logic signed [W-1:0]   mul_a;
    logic signed [2*W-1:0] mul_ext;
    logic signed [2*W-1:0] product;
    logic [2*W-1:0]        prod_shift;
    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      term;
    logic                  take;
    logic                  acc_en;
    logic                  load_out;
    logic                  sat;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        sq_start  = 1'b0;
        mul_a     = x_q;
        acc_en    = 1'b0;
        load_out  = 1'b0;
        take      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    take      = 1'b1;
                    state_nxt = MUL_X;
                end
            end
            MUL_X: begin
                mul_a     = x_q;
                acc_en    = 1'b1;
                state_nxt = MUL_Y;
            end
            MUL_Y: begin
                mul_a     = y_q;
                acc_en    = 1'b1;
                state_nxt = MUL_Z;
            end
            MUL_Z: begin
                mul_a     = z_q;
                acc_en    = 1'b1;
                state_nxt = SUM;
            end
            SUM: begin
                load_out  = 1'b1;
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!ds_busy) begin
                    sq_start  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // 2W-bit signed product holds (-2^(W-1))^2 = 2^(2W-2) without overflow
    assign mul_ext    = {{W{mul_a[W-1]}}, mul_a};
    assign product    = mul_ext * mul_ext;
    assign prod_shift = $unsigned(product) >> FRAC;
    assign term       = {2'b00, prod_shift};
    assign sat        = (acc > SAT_LIMIT);

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= IDLE;
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            acc    <= '0;
            sq_out <= '0;
            sq_sat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                x_q <= x;
                y_q <= y;
                z_q <= z;
                acc <= '0;
            end else if (acc_en) begin
                acc <= acc + term;
            end
            // outputs hold through ISSUE and beyond while downstream samples them
            if (load_out) begin
                sq_out <= sat ? SAT_LIMIT[W-1:0] : acc[W-1:0];
                sq_sat <= sat;
            end
        end
    end

endmodule

// File: tb/tb_vec_len_sq.sv
// Bench for vec_len_sq: directed scenarios plus randomized vectors checked
// against an integer-arithmetic reference of the squared length.
module tb_vec_len_sq;

    localparam int W    = 12;
    localparam int FRAC = 4;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  x = '0, y = '0, z = '0;
    logic          ds_busy = 1'b0;
    logic [W-1:0]  sq_out;
    logic          sq_start;
    logic          sq_sat;

    int n_pass  = 0;
    int n_total = 0;

    vec_len_sq #(.W(W), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .z        (z),
        .ds_busy  (ds_busy),
        .sq_out   (sq_out),
        .sq_start (sq_start),
        .sq_sat   (sq_sat)
    );

    always #5 clk = ~clk;

    // {sat, value}: sum of truncated fixed-point squares, clamped to W bits
    function automatic logic [W:0] ref_sq(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [W-1:0] c);
        int sa, sb, sc, sum, lim;
        sa  = int'($signed(a));
        sb  = int'($signed(b));
        sc  = int'($signed(c));
        sum = (sa*sa) / (1 << FRAC) + (sb*sb) / (1 << FRAC) + (sc*sc) / (1 << FRAC);
        lim = (1 << W) - 1;
        if (sum > lim) return {1'b1, W'(lim)};
        return {1'b0, W'(sum)};
    endfunction

    // Offers a vector from a negedge; returns at the first negedge after the transfer edge
    task automatic transfer(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        x = a; y = b; z = c; in_valid = 1'b1;
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            $display("FAIL transfer_timeout in_ready=%0b required 1", in_ready);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x = W'($urandom); y = W'($urandom); z = W'($urandom);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
        n_total++; if (sq_start !== 1'b0) $display("FAIL reset_sq_start got %0b want 0", sq_start); else n_pass++;
        n_total++; if (sq_out !== '0) $display("FAIL reset_sq_out got %h want 000", sq_out); else n_pass++;
        n_total++; if (sq_sat !== 1'b0) $display("FAIL reset_sq_sat got %0b want 0", sq_sat); else n_pass++;
        rst_ = 1'b1;
    endtask

    task automatic test_latency;
        ds_busy = 1'b0;
        transfer(12'h010, 12'h000, 12'h000);
        for (int k = 1; k <= 4; k++) begin
            n_total++; if (sq_start !== 1'b0 || in_ready !== 1'b0)
                $display("FAIL lat_early cyc=%0d start=%0b ready=%0b want 0/0", k, sq_start, in_ready);
            else n_pass++;
            @(negedge clk);
        end
        n_total++; if (sq_start !== 1'b1) $display("FAIL lat_start got %0b want 1", sq_start); else n_pass++;
        n_total++; if (sq_out !== 12'h010 || sq_sat !== 1'b0)
            $display("FAIL lat_value got %h/%0b want 010/0", sq_out, sq_sat);
        else n_pass++;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_total++; if (sq_start !== 1'b0 || in_ready !== 1'b1)
                $display("FAIL lat_after cyc=%0d start=%0b ready=%0b want 0/1", k, sq_start, in_ready);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_directed;
        logic [W-1:0] tx[5]  = '{12'h020, 12'hFD0, 12'h7FF, 12'h800, 12'h001};
        logic [W-1:0] ty[5]  = '{12'h020, 12'h000, 12'h000, 12'h000, 12'h000};
        logic [W-1:0] tz[5]  = '{12'h020, 12'h000, 12'h000, 12'h000, 12'h000};
        logic [W-1:0] exo[5] = '{12'h0C0, 12'h090, 12'hFFF, 12'hFFF, 12'h000};
        logic         exs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            transfer(tx[i], ty[i], tz[i]);
            repeat (4) @(negedge clk);
            n_total++; if (sq_start !== 1'b1 || sq_out !== exo[i] || sq_sat !== exs[i])
                $display("FAIL directed_%0d got start=%0b out=%h sat=%0b want 1/%h/%0b",
                         i, sq_start, sq_out, sq_sat, exo[i], exs[i]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_busy;
        logic [W-1:0] held;
        ds_busy = 1'b1;
        transfer(12'h800, 12'h000, 12'h000);
        repeat (4) @(negedge clk);
        held = sq_out;
        n_total++; if (held !== 12'hFFF || sq_sat !== 1'b1)
            $display("FAIL busy_value got %h/%0b want FFF/1", held, sq_sat);
        else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (sq_start !== 1'b0 || in_ready !== 1'b0 || sq_out !== held)
                $display("FAIL busy_hold cyc=%0d start=%0b ready=%0b out=%h want 0/0/%h",
                         k, sq_start, in_ready, sq_out, held);
            else n_pass++;
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #1 ds_busy = 1'b0;
        @(negedge clk);
        n_total++; if (sq_start !== 1'b1 || in_ready !== 1'b0 || sq_out !== held)
            $display("FAIL busy_release start=%0b ready=%0b out=%h want 1/0/%h", sq_start, in_ready, sq_out, held);
        else n_pass++;
        @(negedge clk);
        n_total++; if (sq_start !== 1'b0 || in_ready !== 1'b1 || sq_out !== held)
            $display("FAIL busy_single start=%0b ready=%0b out=%h want 0/1/%h", sq_start, in_ready, sq_out, held);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        ds_busy = 1'b0;
        transfer(12'h020, 12'h030, 12'h000);
        @(posedge clk);
        #2 rst_ = 1'b0;
        #1;
        n_total++; if (in_ready !== 1'b1 || sq_start !== 1'b0 || sq_out !== '0 || sq_sat !== 1'b0)
            $display("FAIL rstmid_async ready=%0b start=%0b out=%h sat=%0b want 1/0/000/0",
                     in_ready, sq_start, sq_out, sq_sat);
        else n_pass++;
        @(negedge clk);
        rst_ = 1'b1;
        x = 12'h010; y = 12'h000; z = 12'h000; in_valid = 1'b1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %0b want 1", in_ready); else n_pass++;
        transfer(12'h010, 12'h000, 12'h000);
        for (int k = 1; k <= 4; k++) begin
            n_total++; if (sq_start !== 1'b0) $display("FAIL rstmid_nopulse cyc=%0d got 1 want 0", k); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (sq_start !== 1'b1 || sq_out !== 12'h010 || sq_sat !== 1'b0)
            $display("FAIL rstmid_result start=%0b out=%h sat=%0b want 1/010/0", sq_start, sq_out, sq_sat);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] vx[4], vy[4], vz[4];
        logic [W:0]   exp_q[$];
        logic [W:0]   e;
        int sent = 0, starts = 0, last = -100, prev = 0;
        for (int i = 0; i < 4; i++) begin
            vx[i] = W'($urandom); vy[i] = W'($urandom_range(255)); vz[i] = W'($urandom);
        end
        ds_busy = 1'b0;
        x = vx[0]; y = vy[0]; z = vz[0]; in_valid = 1'b1;
        for (int c = 0; c < 80 && starts < 4; c++) begin
            if (sq_start === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_total++; $display("FAIL b2b_spurious start=1 queued=0 want queued>0");
                end else begin
                    e = exp_q.pop_front();
                    n_total++; if (sq_out !== e[W-1:0] || sq_sat !== e[W])
                        $display("FAIL b2b_value_%0d got %h/%0b want %h/%0b", starts, sq_out, sq_sat, e[W-1:0], e[W]);
                    else n_pass++;
                    if (starts > 0) begin
                        n_total++; if (c - last < 6) $display("FAIL b2b_gap got %0d want >=6", c - last); else n_pass++;
                    end
                    last = c;
                    starts++;
                end
            end
            if (in_ready === 1'b1 && sent < 4) begin
                exp_q.push_back(ref_sq(vx[sent], vy[sent], vz[sent]));
                sent++;
                @(posedge clk);
                #1;
                if (sent < 4) begin x = vx[sent]; y = vy[sent]; z = vz[sent]; end
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        prev = starts;
        repeat (8) begin
            if (sq_start === 1'b1) starts++;
            @(negedge clk);
        end
        n_total++; if (sent !== 4 || starts !== 4 || prev !== 4)
            $display("FAIL b2b_count sent=%0d starts=%0d want 4/4", sent, starts);
        else n_pass++;
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, c;
        logic [W:0]   e;
        for (int i = 0; i < 25; i++) begin
            if (i % 3 == 0) begin
                a = W'($urandom_range(8) - 4); b = W'($urandom_range(8) - 4); c = W'($urandom_range(8) - 4);
            end else begin
                a = W'($urandom); b = W'($urandom_range(1023)); c = W'($urandom);
            end
            e = ref_sq(a, b, c);
            transfer(a, b, c);
            for (int k = 1; k <= 4; k++) begin
                ds_busy = 1'($urandom);
                if (k == 4) ds_busy = 1'b0;
                @(negedge clk);
            end
            n_total++; if (sq_start !== 1'b1 || sq_out !== e[W-1:0] || sq_sat !== e[W])
                $display("FAIL random_%0d in=%h,%h,%h got start=%0b out=%h sat=%0b want 1/%h/%0b",
                         i, a, b, c, sq_start, sq_out, sq_sat, e[W-1:0], e[W]);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
